// File: rtl/carousel_core_routed.sv
`default_nettype none
// ============================================================================
// Module   : carousel_core_routed
// Purpose  : Rotating ring of per-lane slots carrying tagged words to their
//            destination lane, with hold mode and hop-limited drop counting.
// Revision : 1.0 - initial release
// ============================================================================
module carousel_core_routed #(
    parameter int WIDTH       = 8,
    parameter int BUFFER_SIZE = 4,
    parameter int DIRECTION   = 0,
    parameter int MAX_HOPS    = 2 * BUFFER_SIZE,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            shift_en,
    input  logic [BUFFER_SIZE-1:0][WIDTH-1:0]               data_in,
    input  logic [BUFFER_SIZE-1:0][$clog2(BUFFER_SIZE)-1:0] dest_in,
    input  logic [BUFFER_SIZE-1:0]                          data_in_valid,
    output logic [BUFFER_SIZE-1:0]                          data_in_ready,
    output logic [BUFFER_SIZE-1:0][WIDTH-1:0]               data_out,
    output logic [BUFFER_SIZE-1:0]                          data_out_valid,
    input  logic [BUFFER_SIZE-1:0]                          data_out_ready,
    output logic [$clog2(BUFFER_SIZE+1)-1:0]                occupancy,
    output logic [CNT_WIDTH-1:0]                            drop_count
);

    localparam int c_dest_w = $clog2(BUFFER_SIZE);
    localparam int c_hop_w  = (MAX_HOPS == 0) ? 1 : $clog2(MAX_HOPS + 1);
    localparam int c_occ_w  = $clog2(BUFFER_SIZE + 1);
    localparam int c_sum_w  = ((CNT_WIDTH > c_occ_w) ? CNT_WIDTH : c_occ_w) + 1;
    localparam logic [c_dest_w:0]  c_lanes   = (c_dest_w + 1)'(BUFFER_SIZE);
    localparam logic [c_hop_w-1:0] c_hop_max = c_hop_w'(MAX_HOPS);
    localparam logic [c_sum_w-1:0] c_cnt_max = c_sum_w'({CNT_WIDTH{1'b1}});

    typedef struct packed {
        logic                valid;
        logic [c_dest_w-1:0] dest;
        logic [c_hop_w-1:0]  hops;
        logic [WIDTH-1:0]    data;
    } slot_t;

    slot_t                  r_slot [BUFFER_SIZE];
    slot_t                  w_cand [BUFFER_SIZE];
    slot_t                  w_nxt  [BUFFER_SIZE];
    logic [BUFFER_SIZE-1:0] w_fire_out;
    logic [BUFFER_SIZE-1:0] w_cand_fire;
    logic [BUFFER_SIZE-1:0] w_fire_in;
    logic [BUFFER_SIZE-1:0] w_drop;
    logic [c_sum_w-1:0]     w_drop_sum;
    logic [CNT_WIDTH-1:0]   w_drop_cnt_nxt;
    logic [CNT_WIDTH-1:0]   r_drop_cnt;

    always_comb begin
        data_out       = '0;
        data_out_valid = '0;
        w_fire_out     = '0;
        occupancy      = '0;
        for (int k = 0; k < BUFFER_SIZE; k++) begin
            data_out[k]       = r_slot[k].data;
            data_out_valid[k] = r_slot[k].valid && (r_slot[k].dest == c_dest_w'(k));
            w_fire_out[k]     = r_slot[k].valid && (r_slot[k].dest == c_dest_w'(k))
                                && data_out_ready[k];
            occupancy         = occupancy + c_occ_w'(r_slot[k].valid);
        end
    end

    // Each slot's candidate is its ring neighbour while rotating, itself while holding.
    for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_src
        localparam int c_nbr = (DIRECTION == 0) ? ((i + 1) % BUFFER_SIZE)
                                                : ((i + BUFFER_SIZE - 1) % BUFFER_SIZE);
        assign w_cand[i]      = shift_en ? r_slot[c_nbr]     : r_slot[i];
        assign w_cand_fire[i] = shift_en ? w_fire_out[c_nbr] : w_fire_out[i];
    end

    always_comb begin
        data_in_ready = '0;
        w_fire_in     = '0;
        w_drop        = '0;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            w_nxt[i]         = w_cand[i];
            data_in_ready[i] = !w_cand[i].valid;
            w_fire_in[i]     = data_in_valid[i] && !w_cand[i].valid;
            if (w_fire_in[i]) begin
                if ({1'b0, dest_in[i]} < c_lanes) begin
                    w_nxt[i].valid = 1'b1;
                    w_nxt[i].dest  = dest_in[i];
                    w_nxt[i].hops  = '0;
                    w_nxt[i].data  = data_in[i];
                end else begin
                    w_nxt[i].valid = 1'b0;
                    w_drop[i]      = 1'b1;
                end
            end else begin
                w_nxt[i].valid = w_cand[i].valid && !w_cand_fire[i];
                if (shift_en) begin
                    w_nxt[i].hops = w_cand[i].hops + c_hop_w'(1);
                    if ((MAX_HOPS != 0) && w_nxt[i].valid && (w_cand[i].hops == c_hop_max)) begin
                        w_nxt[i].valid = 1'b0;
                        w_drop[i]      = 1'b1;
                    end
                end
            end
        end
    end

    // The sum is wide enough that counter plus every lane dropping cannot wrap.
    always_comb begin
        w_drop_sum = c_sum_w'(r_drop_cnt);
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            w_drop_sum = w_drop_sum + c_sum_w'(w_drop[i]);
        end
        w_drop_cnt_nxt = (w_drop_sum > c_cnt_max) ? '1 : w_drop_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                r_slot[i] <= '0;
            end
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                r_slot[i] <= w_nxt[i];
            end
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    assign drop_count = r_drop_cnt;

endmodule
`default_nettype wire
